// File: rtl/l3_wd_pack.sv
// Byte-to-word packer feeding the L3 write stage: rx bytes -> 32-bit words -> small FIFO.
// Define L3_PACK_BIG_ENDIAN_EN to place the first byte of each word in the MSB lane.
module l3_wd_pack #(
  parameter int DEPTH_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_core,
  input  logic        cmd_en,
  input  logic        wr_open,
  input  logic [15:0] wr_size,
  input  logic [7:0]  rx_byte,
  input  logic        rx_vld,
  output logic [31:0] l3_wd,
  output logic        l3_wd_vld,
  input  logic        core_wd_rdy,
  output logic        ovf,
  output logic        pack_done,
  output logic [1:0]  state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PACK  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [15:0]           size_q;
  logic [15:0]           byte_cnt;
  logic [31:0]           asm_q;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  logic        clr;
  logic [1:0]  lane;
  logic [4:0]  shamt;
  logic        accept, last, push, pop, full, push_ok, drop;
  logic [31:0] merged;

  assign clr    = clr_core | cmd_en;
  assign lane   = byte_cnt[1:0];
  // wr_open wins over a coincident byte: that byte belongs to the abandoned transfer.
  assign accept = (state_q == S_PACK) & rx_vld & ~wr_open;
  assign last   = ((byte_cnt + 16'd1) == size_q);

`ifdef L3_PACK_BIG_ENDIAN_EN
  assign shamt = {~lane, 3'b000};
`else
  assign shamt = {lane, 3'b000};
`endif

  assign merged  = asm_q | ({24'd0, rx_byte} << shamt);
  assign push    = accept & ((lane == 2'd3) | last);
  // Downstream handshake: a word transfers on any cycle where l3_wd_vld & core_wd_rdy.
  assign pop     = (count != '0) & core_wd_rdy;
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign push_ok = push & (~full | pop);
  assign drop    = push & ~push_ok;

  always_comb begin
    state_d = state_q;
    if (wr_open) begin
      state_d = (wr_size == 16'd0) ? S_DONE : S_PACK;
    end else begin
      case (state_q)
        S_PACK:  if (accept & last) state_d = S_FLUSH;
        S_FLUSH: if (count == '0) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      size_q   <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (clr) begin
      state_q  <= S_IDLE;
      size_q   <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state_q <= state_d;
      if (wr_open) begin
        size_q   <= wr_size;
        byte_cnt <= '0;
        asm_q    <= '0;
        ovf      <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept) begin
          byte_cnt <= byte_cnt + 16'd1;
          asm_q    <= push ? 32'd0 : merged;
        end
        if (drop) ovf <= 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        case ({push_ok, pop})
          2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
          2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok & ~wr_open & ~clr) mem[wr_ptr] <= merged;
  end

  assign l3_wd     = (count != '0) ? mem[rd_ptr] : 32'd0;
  assign l3_wd_vld = (count != '0);
  assign pack_done = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_l3_wd_pack.sv
// Directed bench for l3_wd_pack: byte driver tasks, expected-word queue scoreboard, summary.
module tb_l3_wd_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_core = 1'b0;
  logic        cmd_en = 1'b0;
  logic        wr_open = 1'b0;
  logic [15:0] wr_size = '0;
  logic [7:0]  rx_byte = '0;
  logic        rx_vld = 1'b0;
  logic [31:0] l3_wd;
  logic        l3_wd_vld;
  logic        core_wd_rdy = 1'b0;
  logic        ovf;
  logic        pack_done;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int beats = 0;
  logic rdy_idle = 1'b0;
  logic [31:0] exp_q[$];

  l3_wd_pack #(.DEPTH_LOG2(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_core(clr_core), .cmd_en(cmd_en),
    .wr_open(wr_open), .wr_size(wr_size), .rx_byte(rx_byte), .rx_vld(rx_vld),
    .l3_wd(l3_wd), .l3_wd_vld(l3_wd_vld), .core_wd_rdy(core_wd_rdy),
    .ovf(ovf), .pack_done(pack_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
`ifdef L3_PACK_BIG_ENDIAN_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  // Scoreboard: every downstream transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pack_done) done_cnt++;
      if (l3_wd_vld && core_wd_rdy) begin
        beats++;
        if (exp_q.size() == 0) check("unexpected_word", {31'd0, l3_wd_vld}, 32'd0);
        else check("word", l3_wd, exp_q.pop_front());
      end
    end
  end

  task automatic open_xfer(input logic [15:0] sz);
    @(posedge clk); #1;
    wr_open = 1'b1;
    wr_size = sz;
    @(posedge clk); #1;
    wr_open = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r);
    @(posedge clk); #1;
    rx_vld = 1'b1;
    rx_byte = b;
    core_wd_rdy = r;
    @(posedge clk); #1;
    rx_vld = 1'b0;
    core_wd_rdy = rdy_idle;
  endtask

  task automatic pulse_clr(input logic use_cmd);
    @(posedge clk); #1;
    if (use_cmd) cmd_en = 1'b1; else clr_core = 1'b1;
    @(posedge clk); #1;
    cmd_en = 1'b0;
    clr_core = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (done_cnt != start) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
    repeat (3) @(posedge clk);
    check({tag, "_once"}, done_cnt - start, 32'd1);
    #1;
  endtask

  initial begin
    int d0, b0;
    logic [7:0] bytes [64];

    // Reset state
    @(negedge clk);
    check("rst_l3_wd", l3_wd, 32'd0);
    check("rst_vld", {31'd0, l3_wd_vld}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_done", {31'd0, pack_done}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Eight bytes, two full words, downstream always ready
    d0 = done_cnt; b0 = beats;
    rdy_idle = 1'b1; core_wd_rdy = 1'b1;
    exp_q.push_back(mk_word(8'h11, 8'h22, 8'h33, 8'h44));
    exp_q.push_back(mk_word(8'h55, 8'h66, 8'h77, 8'h88));
    open_xfer(16'd8);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)), 1'b1);
    wait_done("t1_done", d0, 50);
    check("t1_beats", beats - b0, 32'd2);
    check("t1_ovf", {31'd0, ovf}, 32'd0);
    check("t1_state", {30'd0, state_dbg}, 32'd0);

    // Six bytes: zero-padded partial final word, trailing byte ignored
    d0 = done_cnt; b0 = beats;
    exp_q.push_back(mk_word(8'hA1, 8'hA2, 8'hA3, 8'hA4));
    exp_q.push_back(mk_word(8'hA5, 8'hA6, 8'h00, 8'h00));
    open_xfer(16'd6);
    for (int i = 0; i < 7; i++) send_byte(8'(8'hA1 + i), 1'b1);
    wait_done("t2_done", d0, 50);
    check("t2_beats", beats - b0, 32'd2);
    check("t2_ovf", {31'd0, ovf}, 32'd0);

    // Stalled downstream: third word is dropped and ovf sets
    d0 = done_cnt; b0 = beats;
    rdy_idle = 1'b0; core_wd_rdy = 1'b0;
    exp_q.push_back(mk_word(8'h01, 8'h02, 8'h03, 8'h04));
    exp_q.push_back(mk_word(8'h05, 8'h06, 8'h07, 8'h08));
    open_xfer(16'd12);
    for (int i = 0; i < 12; i++) send_byte(8'(i + 1), 1'b0);
    @(negedge clk);
    check("t3_ovf", {31'd0, ovf}, 32'd1);
    check("t3_vld", {31'd0, l3_wd_vld}, 32'd1);
    check("t3_head", l3_wd, mk_word(8'h01, 8'h02, 8'h03, 8'h04));
    check("t3_state", {30'd0, state_dbg}, 32'd2);
    @(posedge clk); #1;
    rdy_idle = 1'b1; core_wd_rdy = 1'b1;
    wait_done("t3_done", d0, 50);
    check("t3_beats", beats - b0, 32'd2);
    check("t3_ovf_sticky", {31'd0, ovf}, 32'd1);

    // Full FIFO with coincident push/pop: no ovf, order kept across pointer wraps
    d0 = done_cnt; b0 = beats;
    rdy_idle = 1'b0; core_wd_rdy = 1'b0;
    for (int i = 0; i < 64; i++) bytes[i] = 8'(i * 7 + 3);
    for (int w = 0; w < 16; w++)
      exp_q.push_back(mk_word(bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]));
    open_xfer(16'd64);
    check("t4_ovf_cleared", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 64; i++) send_byte(bytes[i], (i >= 8) && ((i % 4) == 3));
    check("t4_full_vld", {31'd0, l3_wd_vld}, 32'd1);
    rdy_idle = 1'b1; core_wd_rdy = 1'b1;
    wait_done("t4_done", d0, 50);
    check("t4_beats", beats - b0, 32'd16);
    check("t4_ovf", {31'd0, ovf}, 32'd0);

    // Zero-length transfer completes immediately
    b0 = beats;
    open_xfer(16'd0);
    @(negedge clk);
    check("t5_done", {31'd0, pack_done}, 32'd1);
    check("t5_vld", {31'd0, l3_wd_vld}, 32'd0);
    @(negedge clk);
    check("t5_done_low", {31'd0, pack_done}, 32'd0);
    check("t5_beats", beats - b0, 32'd0);

    // clr_core mid-transfer with a word waiting, then a clean 4-byte transfer
    rdy_idle = 1'b0; core_wd_rdy = 1'b0;
    open_xfer(16'd8);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b0);
    @(negedge clk);
    check("t6_pre_vld", {31'd0, l3_wd_vld}, 32'd1);
    pulse_clr(1'b0);
    @(negedge clk);
    check("t6_state", {30'd0, state_dbg}, 32'd0);
    check("t6_vld", {31'd0, l3_wd_vld}, 32'd0);
    check("t6_l3_wd", l3_wd, 32'd0);
    d0 = done_cnt; b0 = beats;
    rdy_idle = 1'b1; core_wd_rdy = 1'b1;
    exp_q.push_back(mk_word(8'h01, 8'h02, 8'h03, 8'h04));
    open_xfer(16'd4);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b1);
    wait_done("t6_done", d0, 50);
    check("t6_beats", beats - b0, 32'd1);

    // cmd_en clears a pending word just like clr_core
    rdy_idle = 1'b0; core_wd_rdy = 1'b0;
    open_xfer(16'd8);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hD0 + i), 1'b0);
    pulse_clr(1'b1);
    @(negedge clk);
    check("t7_state", {30'd0, state_dbg}, 32'd0);
    check("t7_vld", {31'd0, l3_wd_vld}, 32'd0);

    // wr_open mid-transfer restarts: FIFO emptied, new size used
    open_xfer(16'd8);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hE0 + i), 1'b0);
    open_xfer(16'd4);
    @(negedge clk);
    check("t8_vld", {31'd0, l3_wd_vld}, 32'd0);
    check("t8_state", {30'd0, state_dbg}, 32'd1);
    d0 = done_cnt; b0 = beats;
    rdy_idle = 1'b1; core_wd_rdy = 1'b1;
    exp_q.push_back(mk_word(8'h21, 8'h22, 8'h23, 8'h24));
    for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), 1'b1);
    wait_done("t8_done", d0, 50);
    check("t8_beats", beats - b0, 32'd1);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
